// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues in-order word fetches, buffers epoch-tagged responses for decode; FETCH_MISALIGN_CHECK_EN halts on misaligned redirect.
// Latency: response to out_valid 1 cycle; redirect to new fetch address and flush pulse 1 cycle.
// Backpressure: issue is gated on inflight + buffered < DEPTH, so the response FIFO can never overflow.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_data,
    output logic        flush,
    output logic        misalign_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(2 * DEPTH + 1);

    logic [31:0]   pc_q;
    logic [31:0]   tail_pc_q;
    logic          epoch_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;
    logic [DEPTH-1:0] tag_q;
    logic [AW-1:0] tag_wr_q;
    logic [AW-1:0] tag_rd_q;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [AW-1:0] fifo_wr_q;
    logic [AW-1:0] fifo_rd_q;
    logic [CW-1:0] fifo_cnt_q;
    logic [CW-1:0] fifo_cnt_d;
    logic          flush_q;
    logic          run_q;
    logic          halted_q;
    logic          misalign_q;

    logic [31:0]   target_pc;
    logic          bad_target;
    logic          issue_fire;
    logic          resp_ok;
    logic          resp_push;
    logic          out_pop;

    assign target_pc = {branch_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    assign bad_target = branch_taken && (branch_pc[1:0] != 2'b00);
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^branch_pc[1:0];
    assign bad_target    = 1'b0;
`endif

    // run_q keeps requests off until the first edge after reset release.
    assign imem_req_valid = run_q && !halted_q && ((inflight_q + fifo_cnt_q) < CW'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign issue_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign resp_ok   = imem_resp_valid && (inflight_q != '0);
    assign resp_push = resp_ok && (tag_q[tag_rd_q] == epoch_q) && !branch_taken;

    assign out_valid = (fifo_cnt_q != '0);
    assign out_pc    = fifo_pc_q[fifo_rd_q];
    assign out_data  = fifo_data_q[fifo_rd_q];
    assign out_pop   = out_valid && out_ready;

    assign flush        = flush_q;
    assign misalign_err = misalign_q;

    assign inflight_d = inflight_q + CW'(issue_fire) - CW'(resp_ok);
    assign fifo_cnt_d = fifo_cnt_q + CW'(resp_push) - CW'(out_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            tail_pc_q  <= RESET_PC;
            epoch_q    <= 1'b0;
            inflight_q <= '0;
            tag_q      <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            flush_q    <= 1'b0;
            run_q      <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            flush_q    <= branch_taken;
            inflight_q <= inflight_d;
            // Tags follow the request even across a redirect; stale ones are filtered on return.
            if (issue_fire) begin
                tag_q[tag_wr_q] <= epoch_q;
                tag_wr_q        <= tag_wr_q + AW'(1);
            end
            if (resp_ok) begin
                tag_rd_q <= tag_rd_q + AW'(1);
            end
            if (branch_taken) begin
                pc_q       <= target_pc;
                tail_pc_q  <= target_pc;
                epoch_q    <= ~epoch_q;
                fifo_wr_q  <= '0;
                fifo_rd_q  <= '0;
                fifo_cnt_q <= '0;
                if (bad_target) begin
                    halted_q   <= 1'b1;
                    misalign_q <= 1'b1;
                end
            end else begin
                if (issue_fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (resp_push) begin
                    fifo_pc_q[fifo_wr_q]   <= tail_pc_q;
                    fifo_data_q[fifo_wr_q] <= imem_resp_data;
                    fifo_wr_q              <= fifo_wr_q + AW'(1);
                    tail_pc_q              <= tail_pc_q + 32'd4;
                end
                if (out_pop) begin
                    fifo_rd_q <= fifo_rd_q + AW'(1);
                end
                fifo_cnt_q <= fifo_cnt_d;
            end
        end
    end
endmodule
